musk_line_fetch: RTL and testbench

- Bus-side read engine sitting directly downstream of the core's memory request path and upstream of the Sysbus.
- Accepts one cache-line read request from the core-side client and drives a single read request onto the Sysbus request channel (reqcyc/reqtag/req with reqack handshake).
- Collects BEATS response beats from the response channel (respcyc/resp with respack) into a line buffer.
- Hands the assembled line back to the client with a valid/ready handshake.

---
 rtl/musk_line_fetch_if.sv | 35 +++
 rtl/musk_line_fetch.sv | 154 +++++++++++++++
 tb/tb_musk_line_fetch.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/musk_line_fetch_if.sv
// Client and Sysbus signal bundle for the line fetch engine.
// All valid/ready pairs (line_req_valid/ready, line_valid/ready, reqcyc/reqack, respcyc/respack) transfer exactly on a rising clk edge where both are 1; the source holds payload stable until then.
interface musk_line_fetch_if #(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 13,
   parameter int BEATS  = 8
);
   logic                    line_req_valid;
   logic [DATA_W-1:0]       line_req_addr;
   logic                    line_req_ready;
   logic                    line_valid;
   logic [DATA_W-1:0]       line_addr;
   logic [BEATS*DATA_W-1:0] line_data;
   logic                    line_err;
   logic                    line_ready;
   logic                    reqcyc;
   logic [TAG_W-1:0]        reqtag;
   logic [DATA_W-1:0]       req;
   logic                    reqack;
   logic                    respcyc;
   logic [DATA_W-1:0]       resp;
   logic                    respack;

   modport slave (
      input  line_req_valid, line_req_addr, line_ready, reqack, respcyc, resp,
      output line_req_ready, line_valid, line_addr, line_data, line_err,
             reqcyc, reqtag, req, respack
   );

   modport master (
      output line_req_valid, line_req_addr, line_ready, reqack, respcyc, resp,
      input  line_req_ready, line_valid, line_addr, line_data, line_err,
             reqcyc, reqtag, req, respack
   );
endinterface

// File: rtl/musk_line_fetch.sv
// Cache-line read engine: one Sysbus read request, BEATS response beats gathered
// into a line buffer, line handed back to the client; aborts on a stall timeout.
module musk_line_fetch #(
   parameter int DATA_W  = 64,
   parameter int TAG_W   = 13,
   parameter int BEATS   = 8,
   parameter int REQ_ID  = 0,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              reset,
   musk_line_fetch_if.slave  bus,
   output logic [1:0]        dbg_state_o
);
   localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
   localparam int CNT_W = $clog2(BEATS);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int LINE_W = BEATS * DATA_W;
   localparam logic [TAG_W-1:0] REQ_ID_V = TAG_W'(REQ_ID);
   localparam logic [TAG_W-1:0] TAG_RD = {1'b1, REQ_ID_V[TAG_W-2:0]};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      COLLECT = 2'd2,
      DELIVER = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    beat_q, beat_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                reqcyc_q, reqcyc_d;
   logic [TAG_W-1:0]    reqtag_q, reqtag_d;
   logic [DATA_W-1:0]   req_q, req_d;
   logic                line_valid_q, line_valid_d;
   logic                line_err_q, line_err_d;
   logic [DATA_W-1:0]   line_addr_q, line_addr_d;
   logic [LINE_W-1:0]   line_data_q, line_data_d;
   logic                respack;
   logic                line_req_ready;
   logic                tmo_hit;

   assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT));

   always_comb begin
      state_d        = state_q;
      beat_d         = beat_q;
      tmo_d          = tmo_q;
      reqtag_d       = reqtag_q;
      req_d          = req_q;
      line_err_d     = line_err_q;
      line_addr_d    = line_addr_q;
      line_data_d    = line_data_q;
      respack        = 1'b0;
      line_req_ready = 1'b0;

      case (state_q)
         IDLE: begin
            line_req_ready = 1'b1;
            if (bus.line_req_valid) begin
               req_d    = {bus.line_req_addr[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
               reqtag_d = TAG_RD;
               tmo_d    = '0;
               state_d  = REQ;
            end
         end
         REQ: begin
            // An ack landing on the timeout cycle still wins: the bus owns the request now.
            if (bus.reqack) begin
               tmo_d   = '0;
               state_d = COLLECT;
            end else if (tmo_hit) begin
               line_err_d  = 1'b1;
               line_addr_d = req_q;
               state_d     = DELIVER;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         COLLECT: begin
            respack = bus.respcyc;
            if (bus.respcyc) begin
               line_data_d[int'(beat_q)*DATA_W +: DATA_W] = bus.resp;
               tmo_d = '0;
               if (beat_q == CNT_W'(BEATS - 1)) begin
                  beat_d      = '0;
                  line_err_d  = 1'b0;
                  line_addr_d = req_q;
                  state_d     = DELIVER;
               end else begin
                  beat_d = beat_q + CNT_W'(1);
               end
            end else if (tmo_hit) begin
               beat_d      = '0;
               line_err_d  = 1'b1;
               line_addr_d = req_q;
               state_d     = DELIVER;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         DELIVER: begin
            if (bus.line_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Both handshake strobes are gated so nothing is accepted while reset is held.
      if (!reset) begin
         respack        = 1'b0;
         line_req_ready = 1'b0;
      end
   end

   assign reqcyc_d     = (state_d == REQ);
   assign line_valid_d = (state_d == DELIVER);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         tmo_q        <= '0;
         reqcyc_q     <= 1'b0;
         reqtag_q     <= '0;
         req_q        <= '0;
         line_valid_q <= 1'b0;
         line_err_q   <= 1'b0;
         line_addr_q  <= '0;
         line_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         tmo_q        <= tmo_d;
         reqcyc_q     <= reqcyc_d;
         reqtag_q     <= reqtag_d;
         req_q        <= req_d;
         line_valid_q <= line_valid_d;
         line_err_q   <= line_err_d;
         line_addr_q  <= line_addr_d;
         line_data_q  <= line_data_d;
      end
   end

   assign bus.line_req_ready = line_req_ready;
   assign bus.respack        = respack;
   assign bus.reqcyc         = reqcyc_q;
   assign bus.reqtag         = reqtag_q;
   assign bus.req            = req_q;
   assign bus.line_valid     = line_valid_q;
   assign bus.line_err       = line_err_q;
   assign bus.line_addr      = line_addr_q;
   assign bus.line_data      = line_data_q;
   assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_musk_line_fetch.sv
// Directed bench for musk_line_fetch: basic fetch, stalls, back-pressure,
// timeout abort, reset mid-collect and back-to-back requests.
module tb_musk_line_fetch;
   localparam int DATA_W = 64;
   localparam int TAG_W  = 13;
   localparam int BEATS  = 8;
   localparam int LINE_W = BEATS * DATA_W;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_COLLECT = 2'd2;
   localparam logic [1:0] S_DELIVER = 2'd3;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;
   int         n_cmp;
   int         n_err;
   logic [DATA_W-1:0] exp_q[$];
   logic [LINE_W-1:0] held_line;

   musk_line_fetch_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .BEATS(BEATS)) bus ();

   musk_line_fetch #(
      .DATA_W(DATA_W), .TAG_W(TAG_W), .BEATS(BEATS), .REQ_ID(0), .TIMEOUT(15)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave),
      .dbg_state_o(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of run, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_reqcyc"}, bus.reqcyc, 0);
      chk({tag, "_reqtag"}, bus.reqtag, 0);
      chk({tag, "_req"}, bus.req, 0);
      chk({tag, "_lvalid"}, bus.line_valid, 0);
      chk({tag, "_lerr"}, bus.line_err, 0);
      chk({tag, "_laddr"}, bus.line_addr, 0);
      chk({tag, "_ldata"}, bus.line_data, 0);
      chk({tag, "_respack"}, bus.respack, 0);
      chk({tag, "_lreq_rdy"}, bus.line_req_ready, 0);
   endtask

   // driver tasks
   task automatic request(input string tag, input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] exp_req);
      chk({tag, "_idle_rdy"}, bus.line_req_ready, 1);
      bus.line_req_valid = 1'b1;
      bus.line_req_addr  = addr;
      cyc();
      bus.line_req_valid = 1'b0;
      bus.line_req_addr  = '0;
      chk({tag, "_reqcyc_up"}, bus.reqcyc, 1);
      chk({tag, "_req"}, bus.req, exp_req);
      chk({tag, "_reqtag"}, bus.reqtag, 13'h1000);
   endtask

   task automatic ack_after(input string tag, input int n, input logic [DATA_W-1:0] exp_req);
      for (int i = 0; i < n; i++) begin
         cyc();
         chk({tag, "_hold_cyc"}, bus.reqcyc, 1);
         chk({tag, "_hold_req"}, bus.req, exp_req);
      end
      bus.reqack = 1'b1;
      cyc();
      bus.reqack = 1'b0;
      chk({tag, "_reqcyc_down"}, bus.reqcyc, 0);
      chk({tag, "_st_collect"}, dbg_state, S_COLLECT);
   endtask

   task automatic feed_beats(input string tag, input logic [DATA_W-1:0] base, input int n, input bit gap);
      for (int k = 0; k < n; k++) begin
         bus.respcyc = 1'b1;
         bus.resp    = base * DATA_W'(k + 1);
         exp_q.push_back(base * DATA_W'(k + 1));
         #1;
         chk({tag, "_respack_on"}, bus.respack, 1);
         cyc();
         bus.respcyc = 1'b0;
         bus.resp    = '0;
         if (gap && k < n - 1) begin
            #1;
            chk({tag, "_respack_gap"}, bus.respack, 0);
            cyc();
         end
      end
   endtask

   task automatic check_line(input string tag, input logic [DATA_W-1:0] exp_addr);
      logic [LINE_W-1:0] exp_line;
      exp_line = '0;
      for (int k = 0; k < BEATS; k++) begin
         if (exp_q.size() > 0) exp_line[k*DATA_W +: DATA_W] = exp_q.pop_front();
      end
      chk({tag, "_lvalid"}, bus.line_valid, 1);
      chk({tag, "_laddr"}, bus.line_addr, exp_addr);
      chk({tag, "_lerr"}, bus.line_err, 0);
      chk({tag, "_ldata"}, bus.line_data, exp_line);
   endtask

   task automatic take_line(input string tag);
      bus.line_ready = 1'b1;
      cyc();
      bus.line_ready = 1'b0;
      chk({tag, "_lvalid_drop"}, bus.line_valid, 0);
      chk({tag, "_st_idle"}, dbg_state, S_IDLE);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      bus.line_req_valid = 1'b0;
      bus.line_req_addr  = '0;
      bus.line_ready     = 1'b0;
      bus.reqack         = 1'b0;
      bus.respcyc        = 1'b1;
      bus.resp           = 64'hdead;

      // reset held two cycles with a stray beat on the bus
      cyc();
      cyc();
      check_reset_vals("rst");
      bus.respcyc = 1'b0;
      reset = 1'b1;
      cyc();

      // basic fetch
      request("basic", 64'h1038, 64'h1000);
      ack_after("basic", 3, 64'h1000);
      feed_beats("basic", 64'h11, BEATS, 1'b0);
      check_line("basic", 64'h1000);
      take_line("basic");

      // stalled ack and gapped beats
      request("stall", 64'h2fff, 64'h2fc0);
      ack_after("stall", 10, 64'h2fc0);
      feed_beats("stall", 64'h11, BEATS, 1'b1);
      check_line("stall", 64'h2fc0);
      take_line("stall");

      // back-pressure with ignored traffic
      request("bp", 64'h3040, 64'h3040);
      ack_after("bp", 1, 64'h3040);
      feed_beats("bp", 64'h0101_0101_0101_0101, BEATS, 1'b0);
      held_line = bus.line_data;
      check_line("bp", 64'h3040);
      bus.line_req_valid = 1'b1;
      bus.line_req_addr  = 64'h9000;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            bus.respcyc = 1'b1;
            bus.resp    = 64'hbad0_bad0;
            bus.reqack  = 1'b1;
            #1;
            chk("bp_respack_off", bus.respack, 0);
         end
         chk("bp_lreq_rdy", bus.line_req_ready, 0);
         cyc();
         bus.respcyc = 1'b0;
         bus.reqack  = 1'b0;
         chk("bp_lvalid_hold", bus.line_valid, 1);
         chk("bp_ldata_hold", bus.line_data, held_line);
         chk("bp_reqcyc_off", bus.reqcyc, 0);
      end
      bus.line_req_valid = 1'b0;
      bus.line_req_addr  = '0;
      take_line("bp");
      cyc();
      chk("bp_no_stray_req", bus.reqcyc, 0);

      // timeout: no reqack, error line 16 cycles after entering REQ
      request("tmo", 64'h4000, 64'h4000);
      for (int i = 0; i < 16; i++) begin
         chk("tmo_reqcyc_on", bus.reqcyc, 1);
         chk("tmo_lvalid_off", bus.line_valid, 0);
         cyc();
      end
      chk("tmo_lvalid", bus.line_valid, 1);
      chk("tmo_lerr", bus.line_err, 1);
      chk("tmo_reqcyc_off", bus.reqcyc, 0);
      chk("tmo_laddr", bus.line_addr, 64'h4000);
      bus.respcyc = 1'b1;
      bus.resp    = 64'h77;
      #1;
      chk("tmo_late_respack", bus.respack, 0);
      bus.respcyc = 1'b0;
      take_line("tmo");

      // reset after beat 4 of a collect
      request("rmid", 64'h5000, 64'h5000);
      ack_after("rmid", 1, 64'h5000);
      feed_beats("rmid", 64'h33, 4, 1'b0);
      exp_q.delete();
      reset = 1'b0;
      bus.respcyc = 1'b1;
      bus.resp    = 64'h55;
      cyc();
      check_reset_vals("rmid");
      chk("rmid_st_idle", dbg_state, S_IDLE);
      bus.respcyc = 1'b0;
      reset = 1'b1;
      cyc();
      request("fresh", 64'h50bf, 64'h5080);
      ack_after("fresh", 2, 64'h5080);
      feed_beats("fresh", 64'h1_0000_0001, BEATS, 1'b0);
      check_line("fresh", 64'h5080);
      take_line("fresh");

      // back-to-back with line_ready tied high
      bus.line_ready = 1'b1;
      request("b2b1", 64'h6000, 64'h6000);
      ack_after("b2b1", 1, 64'h6000);
      feed_beats("b2b1", 64'h21, BEATS, 1'b0);
      check_line("b2b1", 64'h6000);
      bus.line_req_valid = 1'b1;
      bus.line_req_addr  = 64'h7010;
      cyc();
      chk("b2b_idle_lvalid", bus.line_valid, 0);
      chk("b2b_idle_reqcyc", bus.reqcyc, 0);
      request("b2b2", 64'h7010, 64'h7000);
      ack_after("b2b2", 1, 64'h7000);
      feed_beats("b2b2", 64'h42, BEATS, 1'b0);
      check_line("b2b2", 64'h7000);
      cyc();
      chk("b2b2_lvalid_drop", bus.line_valid, 0);
      chk("b2b2_st_idle", dbg_state, S_IDLE);
      bus.line_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
